// File: rtl/video_pkg.sv
// Shared types, constants and helpers for the video timing generator.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_NOISE = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRID  = 2'd2,
        PAT_RAMP  = 2'd3
    } pattern_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 in right-shift form map to state bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = ^(s & LFSR_TAP_MASK);
        return {fb, s[15:1]};
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int bar_width(input int active);
        return active / 8;
    endfunction

endpackage

// File: rtl/video_pattern.sv
// Test-pattern generator: noise LFSR, colour bars, grid and ramp, with
// registered RGB that updates on the same pixel enable as the timing outputs.
module video_pattern
    import video_pkg::*;
#(
    parameter int DW       = 8,
    parameter int H_ACTIVE = 320,
    parameter int H_TOTAL  = 400,
    parameter int HW       = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  pattern_e      mode_q,
    input  logic [HW-1:0] hcnt,
    input  logic [3:0]    vcnt,
    input  logic          blank,
    output logic [DW-1:0] r,
    output logic [DW-1:0] g,
    output logic [DW-1:0] b
);

    localparam int BAR_W = bar_width(H_ACTIVE);
    localparam int BW    = $clog2(BAR_W + 1);

    logic [15:0]   lfsr_q, lfsr_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [7:0]    x8;
    logic [DW+7:0] ramp_wide;
    logic [DW-1:0] noise, ramp;
    logic          grid_on;

    always_comb begin
        lfsr_d    = lfsr_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;

        x8        = 8'(hcnt);
        ramp_wide = {x8, {DW{1'b0}}};
        ramp      = ramp_wide[DW+7 -: DW];
        noise     = DW'(lfsr_q);
        grid_on   = (hcnt[3:0] == 4'd0) || (vcnt == 4'd0);

        if (ce_pix) begin
            lfsr_d = lfsr_next(lfsr_q);

            // Bar index follows a pixel-width counter so no divider is needed.
            if (hcnt == HW'(H_TOTAL - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (bar_cnt_q == BW'(BAR_W - 1)) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + BW'(1);
            end

            if (blank) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else begin
                case (mode_q)
                    PAT_NOISE: begin
                        r_d = noise;
                        g_d = noise;
                        b_d = noise;
                    end
                    PAT_BARS: begin
                        r_d = {DW{bar_idx_q[1]}};
                        g_d = {DW{bar_idx_q[2]}};
                        b_d = {DW{bar_idx_q[0]}};
                    end
                    PAT_GRID: begin
                        r_d = {DW{grid_on}};
                        g_d = {DW{grid_on}};
                        b_d = {DW{grid_on}};
                    end
                    PAT_RAMP: begin
                        r_d = ramp;
                        g_d = ramp;
                        b_d = ramp;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= LFSR_SEED;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign r = r_q;
    assign g = g_q;
    assign b = b_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: pixel enable, H/V counters, blank/sync
// decode and test pattern, with NTSC/PAL and scandouble switched per frame.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int  DW         = 8,
    parameter int  CE_DIV     = 8,
    parameter int  H_ACTIVE   = 320,
    parameter int  H_FP       = 8,
    parameter int  H_SYNC     = 32,
    parameter int  H_BP       = 40,
    parameter int  V_ACTIVE_N = 240,
    parameter int  V_TOTAL_N  = 262,
    parameter int  V_ACTIVE_P = 288,
    parameter int  V_TOTAL_P  = 312,
    parameter int  V_FP       = 4,
    parameter int  V_SYNC     = 3,
    localparam int H_TOTAL    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int XW         = $clog2(H_TOTAL),
    localparam int YW         = $clog2(V_TOTAL_P)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pal,
    input  logic          scandouble,
    input  logic [1:0]    mode,
    output logic          ce_pix,
    output logic          hblank,
    output logic          hsync,
    output logic          vblank,
    output logic          vsync,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic [DW-1:0] r,
    output logic [DW-1:0] g,
    output logic [DW-1:0] b
);

    localparam int VW   = $clog2(2 * V_TOTAL_P + 1);
    localparam int DIVW = $clog2(CE_DIV);

    logic [DIVW-1:0] div_q, div_d, div_last;
    logic [XW-1:0]   hcnt_q, hcnt_d, x_q, x_d;
    logic [VW-1:0]   vcnt_q, vcnt_d, vact, vtot, vs_lo, vs_hi;
    logic [YW-1:0]   y_q, y_d, y_c;
    logic            pal_q, pal_d, sd_q, sd_d;
    pattern_e        mode_q, mode_d;
    logic            ce_pix_q, ce_pix_d, frame_start_q, frame_start_d;
    logic            hblank_q, hblank_d, hsync_q, hsync_d;
    logic            vblank_q, vblank_d, vsync_q, vsync_d;
    logic            tick, h_wrap, v_wrap;
    logic            hblank_c, hsync_c, vblank_c, vsync_c;

    always_comb begin
        tick     = (div_q == '0);
        div_last = sd_q ? DIVW'(CE_DIV / 2 - 1) : DIVW'(CE_DIV - 1);
        div_d    = (div_q == div_last) ? '0 : div_q + DIVW'(1);

        vact = pal_q ? VW'(V_ACTIVE_P) : VW'(V_ACTIVE_N);
        vtot = pal_q ? VW'(V_TOTAL_P) : VW'(V_TOTAL_N);
        if (sd_q) begin
            vact = vact << 1;
            vtot = vtot << 1;
        end
        vs_lo = vact + (sd_q ? VW'(2 * V_FP) : VW'(V_FP));
        vs_hi = vact + (sd_q ? VW'(2 * (V_FP + V_SYNC)) : VW'(V_FP + V_SYNC));

        h_wrap   = (hcnt_q == XW'(H_TOTAL - 1));
        v_wrap   = (vcnt_q == vtot - VW'(1));
        hblank_c = (hcnt_q >= XW'(H_ACTIVE));
        hsync_c  = (hcnt_q >= XW'(H_ACTIVE + H_FP)) && (hcnt_q < XW'(H_ACTIVE + H_FP + H_SYNC));
        vblank_c = (vcnt_q >= vact);
        vsync_c  = (vcnt_q >= vs_lo) && (vcnt_q < vs_hi);
        y_c      = sd_q ? YW'(vcnt_q >> 1) : YW'(vcnt_q);

        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        pal_d         = pal_q;
        sd_d          = sd_q;
        mode_d        = mode_q;
        hblank_d      = hblank_q;
        hsync_d       = hsync_q;
        vblank_d      = vblank_q;
        vsync_d       = vsync_q;
        x_d           = x_q;
        y_d           = y_q;
        ce_pix_d      = tick;
        frame_start_d = tick && (hcnt_q == '0) && (vcnt_q == '0);

        if (tick) begin
            hblank_d = hblank_c;
            hsync_d  = hsync_c;
            vblank_d = vblank_c;
            vsync_d  = vsync_c;
            x_d      = hcnt_q;
            y_d      = y_c;

            // Line and frame settings only change at their own boundaries.
            if (h_wrap) begin
                hcnt_d = '0;
                mode_d = pattern_e'(mode);
                if (v_wrap) begin
                    vcnt_d = '0;
                    pal_d  = pal;
                    sd_d   = scandouble;
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                end
            end else begin
                hcnt_d = hcnt_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pal_q         <= pal;
            sd_q          <= 1'b0;
            mode_q        <= PAT_NOISE;
            ce_pix_q      <= 1'b0;
            frame_start_q <= 1'b0;
            hblank_q      <= 1'b1;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b1;
            vsync_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
        end else begin
            div_q         <= div_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pal_q         <= pal_d;
            sd_q          <= sd_d;
            mode_q        <= mode_d;
            ce_pix_q      <= ce_pix_d;
            frame_start_q <= frame_start_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    video_pattern #(
        .DW       (DW),
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .HW       (XW)
    ) u_pattern (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (tick),
        .mode_q (mode_q),
        .hcnt   (hcnt_q),
        .vcnt   (y_c[3:0]),
        .blank  (hblank_c | vblank_c),
        .r      (r),
        .g      (g),
        .b      (b)
    );

    assign ce_pix      = ce_pix_q;
    assign frame_start = frame_start_q;
    assign hblank      = hblank_q;
    assign hsync       = hsync_q;
    assign vblank      = vblank_q;
    assign vsync       = vsync_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a pixel model pushes the expected
// output of each pixel, which is popped and compared when the DUT emits it.
module tb_video_timing_gen;

   localparam int CE_DIV_P = 4;
   localparam int H_ACT    = 16;
   localparam int H_FP_P   = 2;
   localparam int H_SYNC_P = 2;
   localparam int H_BP_P   = 4;
   localparam int H_TOT    = H_ACT + H_FP_P + H_SYNC_P + H_BP_P;
   localparam int V_ACT_N  = 4;
   localparam int V_TOT_N  = 8;
   localparam int V_ACT_P  = 6;
   localparam int V_TOT_P  = 10;
   localparam int V_FP_P   = 1;
   localparam int V_SYNC_P = 1;
   localparam int BAR_W    = H_ACT / 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       pal;
   logic       scandouble;
   logic [1:0] mode;
   logic       ce_pix, hblank, hsync, vblank, vsync, frameStart;
   logic [4:0] x;
   logic [3:0] y;
   logic [7:0] r, g, b;

   typedef struct {
      int x;
      int y;
      bit hb;
      bit hs;
      bit vb;
      bit vs;
      bit fs;
      int r;
      int g;
      int b;
      int period;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   int          mH, mV, mMode;
   bit          mPal, mSd;
   logic [15:0] mLfsr;
   bit          checkPeriod;

   always #5 clk = ~clk;

   video_timing_gen #(
      .DW(8), .CE_DIV(CE_DIV_P), .H_ACTIVE(H_ACT), .H_FP(H_FP_P), .H_SYNC(H_SYNC_P), .H_BP(H_BP_P),
      .V_ACTIVE_N(V_ACT_N), .V_TOTAL_N(V_TOT_N), .V_ACTIVE_P(V_ACT_P), .V_TOTAL_P(V_TOT_P),
      .V_FP(V_FP_P), .V_SYNC(V_SYNC_P)
   ) dut (
      .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble), .mode(mode),
      .ce_pix(ce_pix), .hblank(hblank), .hsync(hsync), .vblank(vblank), .vsync(vsync),
      .x(x), .y(y), .frame_start(frameStart), .r(r), .g(g), .b(b)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input bit p, input bit s, input int md);
      pal        = p;
      scandouble = s;
      mode       = 2'(md);
      $display("[TB] stimulus pal=%0d scandouble=%0d mode=%0d", p, s, md);
   endtask

   task automatic modelReset();
      mH          = 0;
      mV          = 0;
      mMode       = 0;
      mPal        = pal;
      mSd         = 1'b0;
      mLfsr       = 16'hACE1;
      checkPeriod = 1'b0;
      sb.delete();
   endtask

   // Builds the expected record for the next pixel, then steps the model.
   task automatic expectPixel();
      exp_t e;
      int   k, vact, vtot, bar, lv;
      bit   on, fb;
      k    = mSd ? 2 : 1;
      vact = (mPal ? V_ACT_P : V_ACT_N) * k;
      vtot = (mPal ? V_TOT_P : V_TOT_N) * k;
      e.x  = mH;
      e.y  = mV / k;
      e.hb = (mH >= H_ACT);
      e.hs = (mH >= H_ACT + H_FP_P) && (mH < H_ACT + H_FP_P + H_SYNC_P);
      e.vb = (mV >= vact);
      e.vs = (mV >= vact + V_FP_P * k) && (mV < vact + (V_FP_P + V_SYNC_P) * k);
      e.fs = (mH == 0) && (mV == 0);
      e.period = mSd ? CE_DIV_P / 2 : CE_DIV_P;
      e.r = 0;
      e.g = 0;
      e.b = 0;
      if (!e.hb && !e.vb) begin
         case (mMode)
            0: begin
               lv = int'(mLfsr) % 256;
               e.r = lv; e.g = lv; e.b = lv;
            end
            1: begin
               bar = mH / BAR_W;
               e.r = (bar & 2) != 0 ? 255 : 0;
               e.g = (bar & 4) != 0 ? 255 : 0;
               e.b = (bar & 1) != 0 ? 255 : 0;
            end
            2: begin
               on = (mH % 16 == 0) || (e.y % 16 == 0);
               e.r = on ? 255 : 0; e.g = e.r; e.b = e.r;
            end
            default: begin
               e.r = mH % 256; e.g = e.r; e.b = e.r;
            end
         endcase
      end
      sb.push_back(e);

      fb    = mLfsr[0] ^ mLfsr[2] ^ mLfsr[3] ^ mLfsr[5];
      mLfsr = (mLfsr >> 1) | (16'(fb) << 15);
      if (mH == H_TOT - 1) begin
         mH    = 0;
         mMode = int'(mode);
         if (mV == vtot - 1) begin
            mV   = 0;
            mPal = pal;
            mSd  = scandouble;
         end else begin
            mV++;
         end
      end else begin
         mH++;
      end
   endtask

   // Waits (bounded) for the next ce_pix and compares it with the oldest expectation.
   task automatic checkOutput();
      exp_t e;
      int   waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (ce_pix !== 1'b1 && waited < 20);
      checkVal("ce_pix_seen", 32'(ce_pix), 32'd1);
      checkVal("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      if (checkPeriod) checkVal("ce_period", 32'(waited), 32'(e.period));
      else             checkVal("first_ce_latency", 32'(waited), 32'd1);
      checkPeriod = 1'b1;
      checkVal("x", 32'(x), 32'(e.x));
      checkVal("y", 32'(y), 32'(e.y));
      checkVal("hblank", 32'(hblank), 32'(e.hb));
      checkVal("hsync", 32'(hsync), 32'(e.hs));
      checkVal("vblank", 32'(vblank), 32'(e.vb));
      checkVal("vsync", 32'(vsync), 32'(e.vs));
      checkVal("frame_start", 32'(frameStart), 32'(e.fs));
      checkVal("r", 32'(r), 32'(e.r));
      checkVal("g", 32'(g), 32'(e.g));
      checkVal("b", 32'(b), 32'(e.b));
   endtask

   task automatic runPixels(input int n);
      for (int i = 0; i < n; i++) begin
         expectPixel();
         checkOutput();
      end
   endtask

   task automatic checkReset();
      checkVal("rst_ce_pix", 32'(ce_pix), 32'd0);
      checkVal("rst_hblank", 32'(hblank), 32'd1);
      checkVal("rst_vblank", 32'(vblank), 32'd1);
      checkVal("rst_hsync", 32'(hsync), 32'd0);
      checkVal("rst_vsync", 32'(vsync), 32'd0);
      checkVal("rst_x", 32'(x), 32'd0);
      checkVal("rst_y", 32'(y), 32'd0);
      checkVal("rst_frame_start", 32'(frameStart), 32'd0);
      checkVal("rst_r", 32'(r), 32'd0);
      checkVal("rst_g", 32'(g), 32'd0);
      checkVal("rst_b", 32'(b), 32'd0);
   endtask

   // Directed sequence: noise, PAL switch, scandouble, bars, ramp, mid-line reset.
   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0);
      repeat (2) @(negedge clk);
      checkReset();
      @(negedge clk);
      reset = 1'b0;
      modelReset();

      runPixels(1);
      checkVal("first_noise_pixel", 32'(r), 32'hE1);
      runPixels(6 * 192 - 1);

      runPixels(3 * 24 + 5);
      applyStimulus(1, 0, 2);
      runPixels(192 - 77);
      runPixels(240);

      runPixels(100);
      applyStimulus(0, 1, 1);
      runPixels(140);
      runPixels(384);

      runPixels(30);
      applyStimulus(0, 1, 3);
      runPixels(100);

      for (int i = 0; i < 64 && mH != 10; i++) runPixels(1);
      checkVal("x_before_reset", 32'(x), 32'd9);
      #1 reset = 1'b1;
      #1 checkReset();
      @(negedge clk);
      reset = 1'b0;
      modelReset();
      runPixels(1);
      checkVal("noise_after_reset", 32'(r), 32'hE1);
      runPixels(47);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
